// File: rtl/fifo_rd_stream_adapter_if.sv
// Output stream of the FIFO read adapter: valid/ready handshake with a
// data word and a packet-last marker.
interface fifo_rd_stream_adapter_if #(
  parameter int DSIZE = 8
) ();
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_last;
  logic             m_ready;

  // Producer side: the adapter drives the beat and watches ready.
  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  // Consumer side: the downstream sink.
  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side consumer for the async FIFO. Pops first-word-fall-through words
// into a 2-entry skid buffer, presents them on a valid/ready stream framed
// into PKT_LEN-beat packets, and keeps word/packet counters.
module fifo_rd_stream_adapter #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      rclk,
  input  logic                      rrst,
  input  logic                      enable,
  input  logic                      rempty,
  input  logic [DSIZE-1:0]          rdata,
  output logic                      rinc,
  fifo_rd_stream_adapter_if.master  strm,
  output logic                      busy,
  output logic [CNT_W-1:0]          word_cnt,
  output logic [CNT_W-1:0]          pkt_cnt
);

  localparam int              BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0]   BEAT_LAST = BW'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [DSIZE-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic [BW-1:0]    beat;
  logic             valid;
  logic             last;
  logic             pop;

  // Pop is gated only by local space, so the FIFO never sees m_ready.
  assign rinc  = !rrst & enable & !rempty & (cnt < 2'd2);
  assign valid = (cnt != 2'd0);
  assign last  = valid & (beat == BEAT_LAST);
  assign pop   = valid & strm.m_ready;

  assign strm.m_valid = valid;
  assign strm.m_data  = mem[rd_ptr];
  assign strm.m_last  = last;

  // Occupancy after this cycle's push and pop; a simultaneous pair cancels.
  always_comb begin
    // NOTE: default first so every path assigns cnt_nxt and no latch is inferred.
    cnt_nxt = cnt;
    case ({rinc, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Skid buffer storage, pointers, occupancy and packet beat index.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      // NOTE: the two entries are cleared so m_data reads 0 out of reset; a
      // deep RAM would normally be left unreset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      beat   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rinc) begin
        mem[wr_ptr] <= rdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        beat   <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;
      end
      cnt <= cnt_nxt;
    end
  end

  // Word counter wraps on every pop from the FIFO; packet counter saturates.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (rinc) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (pop && last && (pkt_cnt != CNT_MAX)) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
    end
  end

  // Control FSM: RUN while enabled, DRAIN until the buffer empties, with busy
  // registered alongside the state.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            if (cnt_nxt != 2'd0) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (cnt_nxt == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: a queue stands in for the async FIFO, a
// reference model predicts each beat as it enters the adapter, and a monitor
// compares every accepted beat plus per-cycle status against that model.
module tb_fifo_rd_stream_adapter;

  localparam int DSIZE   = 8;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct {
    logic [DSIZE-1:0] data;
    logic             last;
  } beat_t;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             enable;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] pkt_cnt;

  fifo_rd_stream_adapter_if #(.DSIZE(DSIZE)) s_if ();

  fifo_rd_stream_adapter #(
    .DSIZE   (DSIZE),
    .PKT_LEN (PKT_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .enable   (enable),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .strm     (s_if),
    .busy     (busy),
    .word_cnt (word_cnt),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad   = 0;

  // FIFO contents and reference model state.
  logic [DSIZE-1:0] fifo_q [$];
  beat_t            exp_q  [$];
  int               beat_exp = 0;
  logic [CNT_W-1:0] word_exp = '0;
  logic [CNT_W-1:0] pkt_exp  = '0;
  logic             busy_exp = 1'b0;

  bit   chk_on     = 1'b0;
  bit   rand_ready = 1'b0;
  int   cyc        = 0;
  int   xfer_n     = 0;
  int   last_xfer_cyc  = 0;
  logic last_xfer_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void update_pins();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '1 : fifo_q[0];
  endfunction

  task automatic step();
    @(posedge rclk);
    #2;
    if (rand_ready) s_if.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_seq(input int n, input logic [DSIZE-1:0] first);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + DSIZE'(i));
    update_pins();
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(DSIZE'($urandom));
    update_pins();
  endtask

  task automatic wait_xfer(input int target, input string name);
    int n = 0;
    while (xfer_n < target && n < 60) begin
      step();
      n++;
    end
    check(name, 32'(xfer_n >= target), 1);
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    check(name, 32'(fifo_q.size() == 0 && exp_q.size() == 0), 1);
  endtask

  // FIFO stand-in: a pop sampled mid-cycle removes the head after the edge,
  // and the popped word becomes the next expected beat of the stream.
  initial begin
    logic  rinc_s;
    beat_t e;
    forever begin
      @(negedge rclk);
      rinc_s = rinc;
      @(posedge rclk);
      #1;
      if (rinc_s) begin
        check("pop_while_nonempty", 32'(fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) begin
          e.data   = fifo_q.pop_front();
          e.last   = (beat_exp == PKT_LEN - 1);
          beat_exp = (beat_exp + 1) % PKT_LEN;
          exp_q.push_back(e);
          word_exp = word_exp + 1'b1;
          update_pins();
        end
      end
    end
  end

  // Monitor: status checks every cycle, scoreboard compare on each accepted beat.
  initial begin
    beat_t            e;
    bit               hold_pending;
    logic [DSIZE-1:0] hold_data;
    logic             hold_last;
    bit               rinc_exp;
    hold_pending = 1'b0;
    hold_data    = '0;
    hold_last    = 1'b0;
    forever begin
      @(negedge rclk);
      cyc++;
      if (chk_on) begin
        rinc_exp = !rrst && enable && !rempty && (exp_q.size() < 2);
        check("busy", busy, busy_exp);
        check("m_valid", s_if.m_valid, 32'(exp_q.size() != 0));
        check("rinc", rinc, rinc_exp);
        check("word_cnt", word_cnt, word_exp);
        check("pkt_cnt", pkt_cnt, pkt_exp);
        if (hold_pending && s_if.m_valid) begin
          check("hold_data", s_if.m_data, hold_data);
          check("hold_last", s_if.m_last, hold_last);
        end
        hold_pending = s_if.m_valid && !s_if.m_ready && !rrst;
        hold_data    = s_if.m_data;
        hold_last    = s_if.m_last;
        if (s_if.m_valid && s_if.m_ready && !rrst) begin
          check("sb_has_entry", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("m_data", s_if.m_data, e.data);
            check("m_last", s_if.m_last, e.last);
            if (e.last && pkt_exp != CNT_MAX) pkt_exp = pkt_exp + 1'b1;
          end
          xfer_n++;
          last_xfer_cyc  = cyc;
          last_xfer_last = s_if.m_last;
        end
        busy_exp = enable || (busy_exp && exp_q.size() != 0);
        if (rrst) begin
          exp_q.delete();
          beat_exp     = 0;
          word_exp     = '0;
          pkt_exp      = '0;
          busy_exp     = 1'b0;
          hold_pending = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int c1;
    int c8;

    // T1: reset held two cycles with data available and enable high.
    rrst         = 1'b1;
    enable       = 1'b1;
    s_if.m_ready = 1'b0;
    push_seq(1, 8'hA5);
    @(posedge rclk);
    #2;
    chk_on = 1'b1;
    @(negedge rclk);
    check("t1_rinc", rinc, 0);
    check("t1_m_valid", s_if.m_valid, 0);
    check("t1_m_last", s_if.m_last, 0);
    check("t1_m_data", s_if.m_data, 0);
    check("t1_busy", busy, 0);
    check("t1_word_cnt", word_cnt, 0);
    check("t1_pkt_cnt", pkt_cnt, 0);
    step();
    enable = 1'b0;
    fifo_q.delete();
    update_pins();
    rrst = 1'b0;
    step();

    // T2: eight words streamed at full rate, two packets.
    push_seq(8, 8'h11);
    s_if.m_ready = 1'b1;
    enable       = 1'b1;
    base = xfer_n;
    wait_xfer(base + 1, "t2_first_beat");
    c1 = last_xfer_cyc;
    wait_xfer(base + 8, "t2_all_beats");
    c8 = last_xfer_cyc;
    check("t2_back_to_back", 32'(c8 - c1), 7);
    check("t2_word_cnt", word_cnt, 8);
    check("t2_pkt_cnt", pkt_cnt, 2);

    // T3: backpressure with five words queued.
    s_if.m_ready = 1'b0;
    push_seq(5, 8'h11);
    repeat (6) step();
    check("t3_two_pops", fifo_q.size(), 3);
    check("t3_head_held", s_if.m_data, 8'h11);
    check("t3_valid_held", s_if.m_valid, 1);
    s_if.m_ready = 1'b1;
    base = xfer_n;
    wait_xfer(base + 5, "t3_release");
    repeat (3) step();
    check("t3_no_duplicate", 32'(xfer_n - base), 5);
    check("t3_empty_after", s_if.m_valid, 0);

    // T4: enable dropped with the buffer full.
    s_if.m_ready = 1'b0;
    push_seq(4, 8'h21);
    repeat (4) step();
    check("t4_buffer_full", fifo_q.size(), 2);
    enable       = 1'b0;
    s_if.m_ready = 1'b1;
    @(negedge rclk);
    check("t4_rinc_stops", rinc, 0);
    check("t4_busy_drain1", busy, 1);
    step();
    @(negedge rclk);
    check("t4_busy_drain2", busy, 1);
    check("t4_valid_drain2", s_if.m_valid, 1);
    step();
    @(negedge rclk);
    check("t4_busy_idle", busy, 0);
    check("t4_valid_idle", s_if.m_valid, 0);
    check("t4_fifo_untouched", fifo_q.size(), 2);
    step();
    fifo_q.delete();
    update_pins();

    // T5: reset after two beats of a packet; framing restarts at beat 0.
    push_seq(12, 8'h31);
    enable = 1'b1;
    base = xfer_n;
    wait_xfer(base + 2, "t5_two_beats");
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    base = xfer_n;
    for (int k = 1; k <= 4; k++) begin
      wait_xfer(base + k, "t5_beat_after_reset");
      check("t5_last_position", last_xfer_last, 32'(k == 4));
    end
    wait_drain(100, "t5_drain");

    // Randomised traffic: enable, ready and FIFO fill all vary.
    rand_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) push_rand($urandom_range(1, 3));
      step();
    end
    enable = 1'b1;
    wait_drain(500, "rand_drain");

    // T6: word counter wrap and packet counter saturation (CNT_W=8 here).
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    push_rand(255);
    wait_drain(3000, "t6_drain_a");
    check("t6_word_cnt_max", word_cnt, 8'hFF);
    push_rand(1);
    wait_drain(100, "t6_drain_b");
    check("t6_word_cnt_wrap", word_cnt, 8'h00);
    push_rand(764);
    wait_drain(6000, "t6_drain_c");
    check("t6_pkt_cnt_max", pkt_cnt, 8'hFF);
    check("t6_word_cnt_mod", word_cnt, 8'hFC);
    push_rand(4);
    wait_drain(100, "t6_drain_d");
    check("t6_pkt_cnt_sat", pkt_cnt, 8'hFF);

    rand_ready = 1'b0;
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
